// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared mode encodings and clog2 helper for the N-to-1 arbitrated mux
package mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational rotating-priority picker; search starts one past the base pointer
module rr_pick
    import mux_pkg::*;
#(
    parameter int N    = 4,
    parameter int SELW = (clog2(N) < 1) ? 1 : clog2(N)
) (
    input  logic [N-1:0]    i_req,
    input  logic [SELW-1:0] i_base,
    output logic [SELW-1:0] o_grant,
    output logic            o_grant_valid
);

    logic w_found;
    int   w_idx;

    // Offsets run 1..N so the channel that was last served has the lowest priority.
    always_comb begin
        o_grant = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int k = 1; k <= N; k++) begin
            w_idx = (int'(i_base) + k) % N;
            if (!w_found && i_req[SELW'(w_idx)]) begin
                w_found = 1'b1;
                o_grant = SELW'(w_idx);
            end
        end
    end

    assign o_grant_valid = |i_req;

endmodule

// File: rtl/mux_nto1_arb.sv
// rtl/mux_nto1_arb.sv - N-to-1 registered mux with fixed/round-robin grant; MUX_NTO1_ARB_PARITY_EN adds out_parity
module mux_nto1_arb
    import mux_pkg::*;
#(
    parameter  int W    = 5,
    parameter  int N    = 4,
    localparam int SELW = (clog2(N) < 1) ? 1 : clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N*W-1:0]  in_data,
    input  logic [N-1:0]    in_valid,
    output logic [N-1:0]    in_ready,
    input  logic            mode,
    input  logic [SELW-1:0] sel,
    output logic [W-1:0]    out_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SELW-1:0] out_src
`ifdef MUX_NTO1_ARB_PARITY_EN
    ,
    output logic            out_parity
`endif
);

    localparam int NP = 1 << SELW;

    logic [SELW-1:0] r_ptr;
    logic            r_run;
    logic            r_out_valid;
    logic [W-1:0]    r_out_data;
    logic [SELW-1:0] r_out_src;

    logic [NP-1:0]   w_valid_pad;
    logic            w_fixed_gv;
    logic [SELW-1:0] w_rr_grant;
    logic            w_rr_gv;
    logic [SELW-1:0] w_grant;
    logic            w_gv;
    logic            w_accept;
    logic            w_xfer;
    logic [W-1:0]    w_sel_data;

    // Padding lets an out-of-range sel index safely; the range test kills its grant.
    assign w_valid_pad = NP'(in_valid);
    assign w_fixed_gv  = (int'(sel) < N) && w_valid_pad[sel];

    rr_pick #(
        .N    (N),
        .SELW (SELW)
    ) u_rr_pick (
        .i_req         (in_valid),
        .i_base        (r_ptr),
        .o_grant       (w_rr_grant),
        .o_grant_valid (w_rr_gv)
    );

    assign w_grant  = (mode == MODE_RR) ? w_rr_grant : sel;
    assign w_gv     = (mode == MODE_RR) ? w_rr_gv    : w_fixed_gv;
    assign w_accept = !r_out_valid || out_ready;
    // r_run keeps every in_ready low until the first edge after reset release.
    assign w_xfer   = r_run && w_accept && w_gv;

    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < N; i++) begin
            if (w_grant == SELW'(i)) begin
                w_sel_data = in_data[i*W +: W];
            end
        end
    end

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < N; i++) begin
            if (w_xfer && (w_grant == SELW'(i))) begin
                in_ready[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_src   <= '0;
            r_ptr       <= SELW'(N - 1);
        end else begin
            r_run <= 1'b1;
            if (r_run && w_accept) begin
                r_out_valid <= w_gv;
            end
            if (w_xfer) begin
                r_out_data <= w_sel_data;
                r_out_src  <= w_grant;
                if (mode == MODE_RR) begin
                    r_ptr <= w_grant;
                end
            end
        end
    end

`ifdef MUX_NTO1_ARB_PARITY_EN
    logic r_out_parity;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_parity <= 1'b0;
        end else if (w_xfer) begin
            r_out_parity <= ^w_sel_data;
        end
    end

    assign out_parity = r_out_parity;
`endif

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_src   = r_out_src;

endmodule

// File: tb/tb_mux_nto1_arb.sv
// tb/tb_mux_nto1_arb.sv - self-checking bench for mux_nto1_arb with reference model
module tb_mux_nto1_arb;

    localparam int W    = 5;
    localparam int N    = 4;
    localparam int SELW = 2;

    logic            clk;
    logic            rst_n;
    logic [N*W-1:0]  in_data;
    logic [N-1:0]    in_valid;
    logic [N-1:0]    in_ready;
    logic            mode;
    logic [SELW-1:0] sel;
    logic [W-1:0]    out_data;
    logic            out_valid;
    logic            out_ready;
    logic [SELW-1:0] out_src;
`ifdef MUX_NTO1_ARB_PARITY_EN
    logic            out_parity;
`endif

    mux_nto1_arb #(.W(W), .N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_src   (out_src)
`ifdef MUX_NTO1_ARB_PARITY_EN
        ,
        .out_parity(out_parity)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    bit         m_valid;
    logic [W-1:0] m_data;
    int         m_src;
    int         m_ptr;
    bit         m_run;
    bit         m_par;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid = 0;
        m_data  = '0;
        m_src   = 0;
        m_ptr   = N - 1;
        m_run   = 0;
        m_par   = 0;
    endtask

    function automatic logic [W-1:0] ch_data(input int c);
        return in_data[c*W +: W];
    endfunction

    task automatic model_grant(output int g, output bit gv);
        int c;
        g  = 0;
        gv = 0;
        if (mode == 1'b0) begin
            g  = int'(sel);
            gv = (int'(sel) < N) && in_valid[sel];
        end else begin
            for (int k = 1; k <= N; k++) begin
                c = (m_ptr + k) % N;
                if (!gv && in_valid[c]) begin
                    gv = 1;
                    g  = c;
                end
            end
        end
    endtask

    task automatic set_ch(input int c, input logic [W-1:0] d);
        in_data[c*W +: W] = d;
    endtask

    task automatic check_cycle();
        int g;
        bit gv;
        bit acc;
        logic [N-1:0] exp_ready;
        #1;
        if (!rst_n) model_reset();
        model_grant(g, gv);
        acc = !m_valid || out_ready;
        exp_ready = (m_run && acc && gv) ? N'(1 << g) : '0;
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("out_data",  32'(out_data),  32'(m_data));
        chk("out_src",   32'(out_src),   32'(m_src));
        chk("in_ready",  32'(in_ready),  32'(exp_ready));
`ifdef MUX_NTO1_ARB_PARITY_EN
        chk("out_parity", 32'(out_parity), 32'(m_par));
`endif
    endtask

    task automatic advance();
        int g;
        bit gv;
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            model_grant(g, gv);
            if (m_run && (!m_valid || out_ready)) begin
                if (gv) begin
                    m_valid = 1;
                    m_data  = ch_data(g);
                    m_src   = g;
                    m_par   = ^ch_data(g);
                    if (mode == 1'b1) m_ptr = g;
                end else begin
                    m_valid = 0;
                end
            end
            m_run = 1;
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_data   = '0;
        in_valid  = '0;
        mode      = 1'b0;
        sel       = '0;
        out_ready = 1'b0;
        model_reset();
        @(negedge clk);

        // Reset with every channel requesting
        in_valid = '1;
        in_data  = 20'hABCDE;
        out_ready = 1'b1;
        check_cycle();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_out_src",   32'(out_src),   32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd0);
        advance();

        rst_n = 1'b1;
        check_cycle();
        chk("first_cycle_ready", 32'(in_ready), 32'd0);
        advance();

        // Fixed select of channel 2
        mode = 1'b0;
        sel  = 2'd2;
        in_valid = 4'b0100;
        set_ch(2, 5'h15);
        check_cycle();
        chk("fixed_in_ready", 32'(in_ready), 32'b0100);
        advance();
        in_valid = '0;
        check_cycle();
        chk("fixed_out_data", 32'(out_data), 32'h15);
        chk("fixed_out_src",  32'(out_src),  32'd2);
        advance();

        // Round-robin rotation from a fresh reset
        rst_n = 1'b0;
        check_cycle();
        advance();
        rst_n = 1'b1;
        check_cycle();
        advance();
        mode = 1'b1;
        in_valid = 4'hF;
        out_ready = 1'b1;
        check_cycle();
        advance();
        for (int k = 0; k < 5; k++) begin
            check_cycle();
            chk("rr_seq", 32'(out_src), 32'(k % 4));
            advance();
        end

        // Stall holds the registered beat
        mode = 1'b0;
        sel  = 2'd1;
        in_valid = 4'b0010;
        set_ch(1, 5'h0A);
        check_cycle();
        advance();
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 4'hF;
            in_data  = 20'($urandom);
            check_cycle();
            chk("stall_data",  32'(out_data),  32'h0A);
            chk("stall_ready", 32'(in_ready),  32'd0);
            chk("stall_valid", 32'(out_valid), 32'd1);
            advance();
        end
        out_ready = 1'b1;
        in_valid = 4'b0010;
        set_ch(1, 5'h11);
        check_cycle();
        chk("unstall_ready", 32'(in_ready), 32'b0010);
        advance();
        check_cycle();
        chk("unstall_data", 32'(out_data), 32'h11);
        advance();

        // Fixed select of an idle channel drains the output
        sel = 2'd3;
        in_valid = 4'b0111;
        check_cycle();
        chk("idle_sel_ready", 32'(in_ready), 32'd0);
        advance();
        check_cycle();
        chk("idle_sel_valid", 32'(out_valid), 32'd0);
        advance();

        // Parity of an odd-weight word
        sel = 2'd0;
        in_valid = 4'b0001;
        set_ch(0, 5'b10110);
        check_cycle();
        advance();
        in_valid = '0;
        check_cycle();
        chk("par_valid", 32'(out_valid), 32'd1);
`ifdef MUX_NTO1_ARB_PARITY_EN
        chk("par_value", 32'(out_parity), 32'd1);
`endif
        advance();

        // Randomized traffic with occasional resets and mode flips
        for (int c = 0; c < 3000; c++) begin
            rst_n     = ($urandom_range(0, 99) != 0);
            mode      = 1'($urandom_range(0, 1));
            sel       = 2'($urandom_range(0, 3));
            in_valid  = 4'($urandom);
            in_data   = 20'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            check_cycle();
            advance();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
